// File: rtl/funcionalidade_pkg.sv
// Shared encodings and constants for the function-code arbiter.
package funcionalidade_pkg;

    localparam int N_REQ = 7;
    localparam int CF_W  = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_WAIT  = 2'd2,
        S_REL   = 2'd3
    } state_t;

    localparam logic [CF_W-1:0] CF_NONE = 3'd0;

    // Round-robin pointer step with wrap from the last requester back to A.
    function automatic logic [CF_W-1:0] wrap_inc(input logic [CF_W-1:0] v);
        return (v == CF_W'(N_REQ - 1)) ? '0 : v + 1'b1;
    endfunction

endpackage

// File: rtl/seletor_round_robin.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping past G to A.
module seletor_round_robin
    import funcionalidade_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [CF_W-1:0]  ptr,
    output logic             hit,
    output logic [CF_W-1:0]  idx
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [CF_W-1:0]    off;
    logic [CF_W:0]      sum;

    always_comb begin
        dbl = {req, req};
        // Rotate so that bit 0 of rot is requester ptr; ptr is always below N_REQ.
        rot = N_REQ'(dbl >> ptr);
        hit = |req;
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = CF_W'(i);
        end
        sum = {1'b0, ptr} + {1'b0, off};
        idx = (sum >= (CF_W+1)'(N_REQ)) ? CF_W'(sum - (CF_W+1)'(N_REQ)) : sum[CF_W-1:0];
    end

endmodule

// File: rtl/arbitro_codificador_funcionalidade.sv
// Round-robin arbiter sharing the 3-bit function code between requesters A..G.
// Optional forced-release timeout is compiled in with ARB_TIMEOUT_EN.
//
// state   | meaning
// S_IDLE  | no grant; scanning req from ptr
// S_GRANT | one cycle; code and start pulse are registered out
// S_WAIT  | code held until done (or timeout when enabled)
// S_REL   | one cycle; code cleared, ptr advanced past granted requester
module arbitro_codificador_funcionalidade
    import funcionalidade_pkg::*;
#(
    parameter int HOLD_MAX = 15,
    parameter int TW       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [CF_W-1:0]  cf,
    output logic             cf_valid,
    output logic             start,
    output logic [N_REQ-1:0] grant,
    output logic             busy,
    output logic             timeout_err
);

    state_t          state, state_nxt;
    logic [CF_W-1:0] idx_q, ptr_q, sel_idx;
    logic            sel_hit;
    logic            timeout_hit;

    seletor_round_robin u_sel (
        .req (req),
        .ptr (ptr_q),
        .hit (sel_hit),
        .idx (sel_idx)
    );

`ifdef ARB_TIMEOUT_EN
    logic [TW-1:0] hold_cnt;

    // Counter holds the number of completed WAIT cycles, so HOLD_MAX-1 marks the last allowed one.
    assign timeout_hit = (state == S_WAIT) && !done && (hold_cnt == TW'(HOLD_MAX - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == S_GRANT) hold_cnt <= '0;
            else if (state == S_WAIT) hold_cnt <= hold_cnt + 1'b1;
            if (timeout_hit) timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (sel_hit) state_nxt = S_GRANT;
            S_GRANT: state_nxt = S_WAIT;
            S_WAIT:  if (done || timeout_hit) state_nxt = S_REL;
            S_REL:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the current state, so they trail the state by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            idx_q    <= '0;
            ptr_q    <= '0;
            cf       <= CF_NONE;
            cf_valid <= 1'b0;
            start    <= 1'b0;
            grant    <= '0;
            busy     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && sel_hit) idx_q <= sel_idx;
            if (state == S_REL) ptr_q <= wrap_inc(idx_q);
            start    <= (state == S_GRANT);
            cf_valid <= (state == S_GRANT) || (state == S_WAIT);
            cf       <= ((state == S_GRANT) || (state == S_WAIT)) ? idx_q + 1'b1 : CF_NONE;
            grant    <= ((state == S_GRANT) || (state == S_WAIT)) ? N_REQ'(1) << idx_q : '0;
            busy     <= (state != S_IDLE);
        end
    end

endmodule

// File: tb/tb_arbitro_codificador_funcionalidade.sv
// Directed bench for the function-code arbiter; timeout scenario selected by ARB_TIMEOUT_EN.
module tb_arbitro_codificador_funcionalidade;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] req = '0;
    logic       done = 1'b0;
    logic [2:0] cf;
    logic       cf_valid, start, busy, timeout_err;
    logic [6:0] grant;

    int checks = 0;
    int failures = 0;

    arbitro_codificador_funcionalidade dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .cf          (cf),
        .cf_valid    (cf_valid),
        .start       (start),
        .grant       (grant),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req  = '0;
        done = 1'b0;
        rst  = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_for_start(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        req = 7'h7F;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({cf, cf_valid, start, grant, busy, timeout_err} !== 14'd0) begin
                failures++;
                $display("FAIL reset_outputs cyc=%0d cf=%0d cf_valid=%b start=%b grant=%h busy=%b terr=%b expected all 0",
                         i, cf, cf_valid, start, grant, busy, timeout_err);
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if (start !== 1'b0 || cf !== 3'd0) begin
            failures++;
            $display("FAIL reset_release start=%b cf=%0d expected start=0 cf=0", start, cf);
        end
    endtask

    task automatic test_single();
        bit ok;
        do_reset();
        req = 7'h04;
        wait_for_start(4, ok);
        checks++;
        if (!ok || cf !== 3'd3 || grant !== 7'h04 || cf_valid !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_grant ok=%b cf=%0d grant=%h cf_valid=%b busy=%b expected cf=3 grant=04 valid=1 busy=1",
                     ok, cf, grant, cf_valid, busy);
        end
        req = '0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (start !== 1'b0 || cf !== 3'd3 || grant !== 7'h04) begin
                failures++;
                $display("FAIL single_hold cyc=%0d start=%b cf=%0d grant=%h expected start=0 cf=3 grant=04",
                         i, start, cf, grant);
            end
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (cf !== 3'd3) begin
            failures++;
            $display("FAIL single_done_latency cf=%0d expected 3", cf);
        end
        tick();
        checks++;
        if (cf !== 3'd0 || grant !== 7'h00 || cf_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_release cf=%0d grant=%h cf_valid=%b busy=%b expected cf=0 grant=00 valid=0 busy=1",
                     cf, grant, cf_valid, busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL single_idle busy=%b expected 0", busy);
        end
        // ptr now 3: with A..D requesting, D must win.
        req = 7'h0F;
        wait_for_start(4, ok);
        checks++;
        if (!ok || cf !== 3'd4 || grant !== 7'h08) begin
            failures++;
            $display("FAIL single_ptr_advance ok=%b cf=%0d grant=%h expected cf=4 grant=08", ok, cf, grant);
        end
        req  = '0;
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [2:0] exp_cf;
        logic [6:0] exp_grant;
        do_reset();
        done = 1'b1;
        req  = 7'h7F;
        for (int k = 0; k < 8; k++) begin
            exp_cf    = 3'((k % 7) + 1);
            exp_grant = 7'(1 << (k % 7));
            wait_for_start(8, ok);
            checks++;
            if (!ok || cf !== exp_cf || grant !== exp_grant) begin
                failures++;
                $display("FAIL rr_sequence k=%0d ok=%b cf=%0d grant=%h expected cf=%0d grant=%h",
                         k, ok, cf, grant, exp_cf, exp_grant);
            end
        end
        req = '0;
        tick();
        tick();
        done = 1'b0;
        tick();
    endtask

    task automatic test_drop_req();
        bit ok;
        bit saw_start;
        do_reset();
        req = 7'h20;
        wait_for_start(4, ok);
        checks++;
        if (!ok || cf !== 3'd6 || grant !== 7'h20) begin
            failures++;
            $display("FAIL drop_grant ok=%b cf=%0d grant=%h expected cf=6 grant=20", ok, cf, grant);
        end
        req = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (cf !== 3'd6 || grant !== 7'h20 || cf_valid !== 1'b1) begin
                failures++;
                $display("FAIL drop_hold cyc=%0d cf=%0d grant=%h cf_valid=%b expected cf=6 grant=20 valid=1",
                         i, cf, grant, cf_valid);
            end
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        checks++;
        if (cf !== 3'd0 || grant !== 7'h00 || cf_valid !== 1'b0) begin
            failures++;
            $display("FAIL drop_release cf=%0d grant=%h cf_valid=%b expected 0/00/0", cf, grant, cf_valid);
        end
        saw_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (start === 1'b1) saw_start = 1'b1;
        end
        checks++;
        if (saw_start) begin
            failures++;
            $display("FAIL drop_no_regrant start seen=1 expected 0");
        end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        do_reset();
        req = 7'h02;
        wait_for_start(4, ok);
        req = '0;
        checks++;
        if (!ok || cf !== 3'd2) begin
            failures++;
            $display("FAIL to_grant ok=%b cf=%0d expected cf=2", ok, cf);
        end
        for (int i = 0; i < 14; i++) tick();
        checks++;
        if (cf !== 3'd2 || timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL to_before cf=%0d terr=%b expected cf=2 terr=0", cf, timeout_err);
        end
        tick();
        checks++;
        if (timeout_err !== 1'b1 || cf !== 3'd2) begin
            failures++;
            $display("FAIL to_set terr=%b cf=%0d expected terr=1 cf=2", timeout_err, cf);
        end
        tick();
        checks++;
        if (cf !== 3'd0 || grant !== 7'h00) begin
            failures++;
            $display("FAIL to_release cf=%0d grant=%h expected cf=0 grant=00", cf, grant);
        end
        req = 7'h08;
        wait_for_start(6, ok);
        req = '0;
        checks++;
        if (!ok || cf !== 3'd4 || grant !== 7'h08 || timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL to_next_grant ok=%b cf=%0d grant=%h terr=%b expected cf=4 grant=08 terr=1",
                     ok, cf, grant, timeout_err);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        tick();
        checks++;
        if (cf !== 3'd0 || timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL to_sticky cf=%0d terr=%b expected cf=0 terr=1", cf, timeout_err);
        end
    endtask
`else
    task automatic test_no_timeout();
        bit ok;
        bit held;
        do_reset();
        req = 7'h01;
        wait_for_start(4, ok);
        req  = '0;
        held = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (cf !== 3'd1 || timeout_err !== 1'b0) held = 1'b0;
        end
        checks++;
        if (!ok || !held) begin
            failures++;
            $display("FAIL no_timeout_hold ok=%b held=%b cf=%0d terr=%b expected cf=1 held for 40 cycles terr=0",
                     ok, held, cf, timeout_err);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        checks++;
        if (cf !== 3'd0 || timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL no_timeout_release cf=%0d terr=%b expected cf=0 terr=0", cf, timeout_err);
        end
    endtask
`endif

    task automatic test_reset_mid_wait();
        bit ok;
        do_reset();
        req = 7'h02;
        wait_for_start(4, ok);
        req  = '0;
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        tick();
        // ptr is now 2; B's grant is complete.
        req = 7'h08;
        wait_for_start(6, ok);
        req = '0;
        tick();
        tick();
        checks++;
        if (!ok || cf !== 3'd4) begin
            failures++;
            $display("FAIL rstmid_setup ok=%b cf=%0d expected cf=4", ok, cf);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (cf !== 3'd0 || grant !== 7'h00 || busy !== 1'b0 || cf_valid !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_outputs cf=%0d grant=%h busy=%b cf_valid=%b expected all 0",
                     cf, grant, busy, cf_valid);
        end
        req = 7'h09;
        wait_for_start(4, ok);
        req = '0;
        checks++;
        if (!ok || cf !== 3'd1 || grant !== 7'h01) begin
            failures++;
            $display("FAIL rstmid_ptr ok=%b cf=%0d grant=%h expected cf=1 grant=01", ok, cf, grant);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_drop_req();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
